// File: rtl/mta_pkg.sv
// Shared parameters and types for the multi-tile accelerator slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mta_pkg;
    localparam int DW    = 32;
    localparam int NW    = 2;
    localparam int NH    = 2;
    localparam int EPN   = 2;
    localparam int ITW   = 2;
    localparam int ITH   = 2;
    localparam int ITC   = 1;
    localparam int FRAME = ITW * ITH * ITC;
    localparam int FD    = 4;
    localparam int NT    = NW * NH;
    // inj_cnt wraps inside a frame; ej_cnt must be able to hold FRAME itself
    localparam int IW    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int CW    = $clog2(FRAME + 1);

    typedef logic [DW-1:0] word_t;

    // Index of the last word in a frame owned by tile t, or -1 if it owns none.
    function automatic int tile_last(input int t);
        int r;
        r = -1;
        for (int k = 0; k < FRAME; k++) begin
            if ((k % NT) == t) r = k;
        end
        return r;
    endfunction
endpackage

// File: rtl/mta_if.sv
// Injection/ejection handshake bundle between the stream source/sinks and mta_system.
// Latency: n/a (wires only).
// Backpressure: ready_o_inject throttles injection; ready_i_eject throttles each ejection port.
// Ports: master = stream side (drives inject, sinks eject); slave = mta_system.
interface mta_if;
    import mta_pkg::*;

    word_t                    data_i_inject;
    logic                     valid_i_inject;
    logic                     ready_o_inject;
    logic [EPN-1:0][DW-1:0]   data_o_eject;
    logic [EPN-1:0]           valid_o_eject;
    logic [EPN-1:0]           ready_i_eject;

    modport master (
        output data_i_inject, valid_i_inject, ready_i_eject,
        input  ready_o_inject, data_o_eject, valid_o_eject
    );

    modport slave (
        input  data_i_inject, valid_i_inject, ready_i_eject,
        output ready_o_inject, data_o_eject, valid_o_eject
    );
endinterface

// File: rtl/mta_eject_fifo.sv
// Synchronous FIFO for one ejection port, FD entries of DW bits.
// Latency: word pushed at edge n is at head_dat after edge n (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
// Ports: clk_pc/rstn_nw clock+async reset; push_vld/push_dat write; pop_rdy read; head_dat/full/empty status.
module mta_eject_fifo #(
    parameter int DW = 32,
    parameter int FD = 4
) (
    input  logic          clk_pc,
    input  logic          rstn_nw,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_rdy,
    output logic [DW-1:0] head_dat,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(FD);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [FD];
    logic [DW-1:0] mem_d [FD];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_vld && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_rdy && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_pc or negedge rstn_nw) begin
        if (!rstn_nw) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FD; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/mta_system.sv
// Multi-tile accelerator top: ReLU on injected fp32 words, broadcast to EPN ejection FIFOs, per-tile done flags.
// Latency: word accepted at edge n is valid on every ejection port after edge n.
// Backpressure: ready_o_inject low while any port FIFO is full; each port drains independently.
// Ports: clk_pc/rstn_nw clock+async reset; other clk/rstn reserved; io = slave stream bundle; tile_done[x][y] sticky completion.
module mta_system import mta_pkg::*; (
    input  logic                   clk_pc,
    input  logic                   rstn_nw,
    input  logic                   clk_nw,
    input  logic                   clk_bw,
    input  logic                   clk_br,
    input  logic                   rstn_bw,
    input  logic                   rstn_br,
    input  logic                   rstn_pc,
    mta_if.slave                   io,
    output logic [NW-1:0][NH-1:0]  tile_done
);
    logic                   unused_ok;
    assign unused_ok = &{1'b0, clk_nw, clk_bw, clk_br, rstn_bw, rstn_br, rstn_pc};

    // run_q holds injection off until the first edge after reset release.
    logic                   run_q, run_d;
    logic [IW-1:0]          inj_cnt_q, inj_cnt_d;
    logic [EPN-1:0][CW-1:0] ej_cnt_q, ej_cnt_d;
    logic [NW-1:0][NH-1:0]  tile_done_q, tile_done_d;

    logic [EPN-1:0]         fifo_full;
    logic [EPN-1:0]         fifo_empty;
    logic [EPN-1:0]         pop;
    logic [EPN-1:0][DW-1:0] head_dat;
    word_t                  relu_dat;
    logic                   accept;
    logic [CW-1:0]          min_ej;

    // Negative inputs (including -0.0 and negative NaNs) clamp to +0.0.
    assign relu_dat          = io.data_i_inject[DW-1] ? '0 : io.data_i_inject;
    assign io.ready_o_inject = run_q & ~(|fifo_full);
    assign accept            = io.valid_i_inject & io.ready_o_inject;
    assign pop               = ~fifo_empty & io.ready_i_eject;
    assign io.valid_o_eject  = ~fifo_empty;
    assign io.data_o_eject   = head_dat;
    assign tile_done         = tile_done_q;

    for (genvar p = 0; p < EPN; p++) begin : g_port
        mta_eject_fifo #(.DW(DW), .FD(FD)) u_fifo (
            .clk_pc   (clk_pc),
            .rstn_nw  (rstn_nw),
            .push_vld (accept),
            .push_dat (relu_dat),
            .pop_rdy  (pop[p]),
            .head_dat (head_dat[p]),
            .full     (fifo_full[p]),
            .empty    (fifo_empty[p])
        );
    end

    always_comb begin
        run_d       = 1'b1;
        inj_cnt_d   = inj_cnt_q;
        ej_cnt_d    = ej_cnt_q;
        tile_done_d = tile_done_q;
        min_ej      = ej_cnt_q[0];

        if (accept) begin
            inj_cnt_d = (inj_cnt_q == IW'(FRAME - 1)) ? '0 : inj_cnt_q + IW'(1);
        end

        for (int p = 0; p < EPN; p++) begin
            if (pop[p] && (ej_cnt_q[p] != CW'(FRAME))) begin
                ej_cnt_d[p] = ej_cnt_q[p] + CW'(1);
            end
            if (ej_cnt_q[p] < min_ej) min_ej = ej_cnt_q[p];
        end

        // A tile is done once its last word has left every port.
        for (int x = 0; x < NW; x++) begin
            for (int y = 0; y < NH; y++) begin
                if ((x * NH + y) >= FRAME) begin
                    tile_done_d[x][y] = 1'b1;
                end else if (min_ej > CW'(tile_last(x * NH + y))) begin
                    tile_done_d[x][y] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_pc or negedge rstn_nw) begin
        if (!rstn_nw) begin
            run_q       <= 1'b0;
            inj_cnt_q   <= '0;
            ej_cnt_q    <= '0;
            tile_done_q <= '0;
        end else begin
            run_q       <= run_d;
            inj_cnt_q   <= inj_cnt_d;
            ej_cnt_q    <= ej_cnt_d;
            tile_done_q <= tile_done_d;
        end
    end
endmodule

// File: tb/tb_mta_system.sv
// Self-checking bench for mta_system: scoreboard per ejection port plus a cycle model of ready/valid/tile_done.
// Latency: checks one-cycle push-to-valid and one-cycle pop-to-done timing.
// Backpressure: exercises port skew, full-FIFO injection stall and mid-frame reset.
module tb_mta_system;
    import mta_pkg::*;

    logic clk_pc;
    logic rstn_nw;
    logic clk_nw, clk_bw, clk_br, rstn_bw, rstn_br, rstn_pc;
    logic [NW-1:0][NH-1:0] tile_done;

    mta_if vif();

    mta_system dut (
        .clk_pc    (clk_pc),
        .rstn_nw   (rstn_nw),
        .clk_nw    (clk_nw),
        .clk_bw    (clk_bw),
        .clk_br    (clk_br),
        .rstn_bw   (rstn_bw),
        .rstn_br   (rstn_br),
        .rstn_pc   (rstn_pc),
        .io        (vif),
        .tile_done (tile_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    word_t sb [EPN][$];
    int    ej_m [EPN];
    logic [3:0] td_m;
    bit    run_m;

    initial begin
        clk_pc = 1'b0;
        forever #5 clk_pc = ~clk_pc;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic word_t relu_m(input word_t w);
        return w[31] ? 32'h0 : w;
    endfunction

    function automatic int last_m(input int t);
        int r;
        r = -1;
        for (int k = 0; k < FRAME; k++) if ((k % 4) == t) r = k;
        return r;
    endfunction

    // Per-cycle model, sampled 1 time unit before each rising edge.
    initial begin
        int   mn;
        logic rdy_e;
        td_m  = '0;
        run_m = 1'b0;
        for (int p = 0; p < EPN; p++) ej_m[p] = 0;
        forever begin
            @(negedge clk_pc);
            #4;
            if (!rstn_nw) begin
                check_eq("rst_ready", {31'b0, vif.ready_o_inject}, 32'd0);
                check_eq("rst_valid", {30'b0, vif.valid_o_eject}, 32'd0);
                check_eq("rst_td", {28'b0, tile_done}, 32'd0);
                for (int p = 0; p < EPN; p++) begin
                    sb[p].delete();
                    ej_m[p] = 0;
                end
                td_m  = '0;
                run_m = 1'b0;
            end else begin
                rdy_e = run_m;
                for (int p = 0; p < EPN; p++) begin
                    if (sb[p].size() >= FD) rdy_e = 1'b0;
                    check_eq($sformatf("valid%0d", p), {31'b0, vif.valid_o_eject[p]},
                             {31'b0, sb[p].size() != 0});
                end
                check_eq("ready", {31'b0, vif.ready_o_inject}, {31'b0, rdy_e});
                check_eq("td", {28'b0, tile_done}, {28'b0, td_m});

                mn = ej_m[0];
                for (int p = 1; p < EPN; p++) if (ej_m[p] < mn) mn = ej_m[p];
                for (int t = 0; t < 4; t++) if (mn > last_m(t)) td_m[t] = 1'b1;

                for (int p = 0; p < EPN; p++) begin
                    if (sb[p].size() != 0 && vif.ready_i_eject[p]) begin
                        check_eq($sformatf("data%0d", p), vif.data_o_eject[p], sb[p].pop_front());
                        if (ej_m[p] < FRAME) ej_m[p]++;
                    end
                end
                if (vif.valid_i_inject && rdy_e) begin
                    for (int p = 0; p < EPN; p++) sb[p].push_back(relu_m(vif.data_i_inject));
                end
                run_m = 1'b1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input word_t w);
        bit done;
        done = 1'b0;
        vif.data_i_inject  = w;
        vif.valid_i_inject = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            #3;
            done = vif.ready_o_inject;
            @(negedge clk_pc);
        end
        if (!done) check_eq("send_timeout", 32'd0, 32'd1);
        vif.valid_i_inject = 1'b0;
    endtask

    task automatic wait_port_empty(input int p);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk_pc);
            done = !vif.valid_o_eject[p];
        end
        if (!done) check_eq($sformatf("drain_timeout%0d", p), 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int p = 0; p < EPN; p++) wait_port_empty(p);
        repeat (3) @(negedge clk_pc);
    endtask

    task automatic do_reset();
        @(negedge clk_pc);
        rstn_nw = 1'b0;
        repeat (2) @(negedge clk_pc);
        rstn_nw = 1'b1;
        @(negedge clk_pc);
    endtask

    initial begin
        word_t s1 [4];
        word_t s2 [4];
        s1 = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h80000000};
        s2 = '{32'h40800000, 32'hFF800000, 32'h7FC00000, 32'hFFC00000};
        rstn_nw = 1'b0;
        {clk_nw, clk_bw, clk_br, rstn_bw, rstn_br, rstn_pc} = '0;
        vif.data_i_inject  = '0;
        vif.valid_i_inject = 1'b0;
        vif.ready_i_eject  = '0;

        // Reset state and release
        repeat (3) @(negedge clk_pc);
        #1;
        check_eq("reset_ready", {31'b0, vif.ready_o_inject}, 32'd0);
        check_eq("reset_td", {28'b0, tile_done}, 32'd0);
        @(negedge clk_pc);
        rstn_nw = 1'b1;
        #1;
        check_eq("release_ready_pre", {31'b0, vif.ready_o_inject}, 32'd0);
        @(negedge clk_pc);
        check_eq("release_ready", {31'b0, vif.ready_o_inject}, 32'd1);

        // First frame, both ports ready
        vif.ready_i_eject = 2'b11;
        for (int i = 0; i < 4; i++) send(s1[i]);
        wait_drain();
        check_eq("frame1_td", {28'b0, tile_done}, 32'hF);
        check_eq("frame1_inj", 32'(dut.inj_cnt_q), 32'd0);

        // Second frame after done
        send(s2[0]);
        check_eq("frame2_inj1", 32'(dut.inj_cnt_q), 32'd1);
        for (int i = 1; i < 4; i++) send(s2[i]);
        wait_drain();
        check_eq("frame2_td", {28'b0, tile_done}, 32'hF);
        check_eq("frame2_inj", 32'(dut.inj_cnt_q), 32'd0);

        // Port skew: port 1 stalls while port 0 drains
        do_reset();
        vif.ready_i_eject = 2'b01;
        for (int i = 0; i < 4; i++) send(s1[i]);
        wait_port_empty(0);
        repeat (2) @(negedge clk_pc);
        check_eq("skew_td0", {28'b0, tile_done}, 32'h0);
        check_eq("skew_ready", {31'b0, vif.ready_o_inject}, 32'd0);
        vif.ready_i_eject = 2'b11;
        repeat (2) @(negedge clk_pc);
        check_eq("skew_td1", {28'b0, tile_done}, 32'h1);
        repeat (3) @(negedge clk_pc);
        check_eq("skew_tdall", {28'b0, tile_done}, 32'hF);

        // Back-pressure: port 0 blocked, fifth word stalls
        do_reset();
        vif.ready_i_eject = 2'b10;
        fork
            begin
                for (int i = 0; i < 4; i++) send(s2[i]);
                send(s1[0]);
            end
            begin
                repeat (8) @(negedge clk_pc);
                check_eq("bp_ready_low", {31'b0, vif.ready_o_inject}, 32'd0);
                check_eq("bp_valid0", {31'b0, vif.valid_o_eject[0]}, 32'd1);
                vif.ready_i_eject = 2'b11;
            end
        join
        wait_drain();
        check_eq("bp_td", {28'b0, tile_done}, 32'hF);

        // Reset mid-frame, then a fresh frame
        do_reset();
        vif.ready_i_eject = 2'b00;
        send(s1[0]);
        send(s1[1]);
        check_eq("mid_valid", {30'b0, vif.valid_o_eject}, 32'd3);
        rstn_nw = 1'b0;
        #1;
        check_eq("mid_rst_valid", {30'b0, vif.valid_o_eject}, 32'd0);
        check_eq("mid_rst_td", {28'b0, tile_done}, 32'd0);
        @(negedge clk_pc);
        rstn_nw = 1'b1;
        @(negedge clk_pc);
        vif.ready_i_eject = 2'b11;
        for (int i = 0; i < 4; i++) send(s2[i]);
        wait_drain();
        check_eq("mid_td", {28'b0, tile_done}, 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
